// File: rtl/serial_mult_8.sv
// serial_mult_8: 8x8 unsigned shift-and-add multiplier with a valid/ready handshake on both sides.
// Optional feature macro SERIAL_MULT_ZERO_SKIP_EN: a zero operand bypasses RUN and goes straight to DONE.

module ripple_8 (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);
    logic [8:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < 8; g++) begin : g_fa
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[8];
endmodule

module serial_mult_8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_a,
    input  logic [7:0]  in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [7:0]  r_mcand;
    logic [7:0]  r_acc_hi;
    logic [7:0]  r_acc_lo;

    logic [7:0]  w_addend;
    logic [7:0]  w_sum;
    logic        w_cout;
    logic        w_zero_skip;

`ifdef SERIAL_MULT_ZERO_SKIP_EN
    assign w_zero_skip = (in_a == 8'h00) || (in_b == 8'h00);
`else
    assign w_zero_skip = 1'b0;
`endif

    // A clear multiplier bit adds zero, which is the same as passing acc_hi through.
    assign w_addend = r_acc_lo[0] ? r_mcand : 8'h00;

    ripple_8 u_add (
        .i_a    (r_acc_hi),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= 3'd0;
            r_mcand  <= 8'h00;
            r_acc_hi <= 8'h00;
            r_acc_lo <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_mcand  <= in_a;
                        r_cnt    <= 3'd0;
                        r_acc_hi <= 8'h00;
                        if (w_zero_skip) begin
                            r_acc_lo <= 8'h00;
                            r_state  <= DONE;
                        end else begin
                            r_acc_lo <= in_b;
                            r_state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    // 17-bit right shift so the adder carry lands in acc_hi[7].
                    {r_acc_hi, r_acc_lo} <= {w_cout, w_sum, r_acc_lo[7:1]};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign product   = {r_acc_hi, r_acc_lo};
endmodule

// File: tb/tb_serial_mult_8.sv
// Self-checking bench for serial_mult_8: vector table plus directed handshake, hold, reset and back-to-back sequences.
// Expected latencies follow the SERIAL_MULT_ZERO_SKIP_EN build setting.

module tb_serial_mult_8;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;

    int checks;
    int failures;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[12];

    serial_mult_8 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef SERIAL_MULT_ZERO_SKIP_EN
        if (a == 8'h00 || b == 8'h00) return 0;
`endif
        return 8;
    endfunction

    // Edges counted after the accepting edge until out_valid is seen.
    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p);
        int n;
        n = 0;
        while (!in_ready && n < 30) begin
            step();
            n++;
        end
        chk({name, "_ready_before"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        step();
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = b ^ 8'h5A;
        wait_out(n);
        chk({name, "_latency"}, n, exp_latency(a, b));
        chk({name, "_product"}, {16'd0, product}, {16'd0, exp_p});
        step();
        chk({name, "_idle_after"}, {30'd0, in_ready, out_valid}, 32'd2);
    endtask

    logic [7:0]  ba[3];
    logic [7:0]  bb[3];
    logic [15:0] bp[3];

    initial begin
        int n;
        int extra;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = 8'h00;
        in_b      = 8'h00;
        out_ready = 1'b1;

        vecs[0]  = '{8'd13,  8'd11,  16'h008F};
        vecs[1]  = '{8'd255, 8'd255, 16'hFE01};
        vecs[2]  = '{8'd0,   8'd77,  16'h0000};
        vecs[3]  = '{8'd77,  8'd0,   16'h0000};
        vecs[4]  = '{8'd1,   8'd1,   16'h0001};
        vecs[5]  = '{8'd128, 8'd2,   16'h0100};
        vecs[6]  = '{8'd15,  8'd17,  16'h00FF};
        vecs[7]  = '{8'd128, 8'd128, 16'h4000};
        vecs[8]  = '{8'hAA,  8'h55,  16'h3872};
        vecs[9]  = '{8'hFF,  8'h01,  16'h00FF};
        vecs[10] = '{8'hFF,  8'h80,  16'h7F80};
        vecs[11] = '{8'd7,   8'd9,   16'h003F};

        ba[0] = 8'd1;   bb[0] = 8'd1;  bp[0] = 16'h0001;
        ba[1] = 8'd128; bb[1] = 8'd2;  bp[1] = 16'h0100;
        ba[2] = 8'd15;  bb[2] = 8'd17; bp[2] = 16'h00FF;

        #12;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_product", {16'd0, product}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].p);
        end

        // Backpressure: DONE and product hold, new operands are ignored.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'd200;
        in_b      = 8'd3;
        step();
        in_valid = 1'b0;
        wait_out(n);
        chk("hold_latency", n, 8);
        chk("hold_product", {16'd0, product}, 32'h0258);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2) == 0;
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            step();
            chk($sformatf("hold_valid_%0d", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("hold_prod_%0d", i), {16'd0, product}, 32'h0258);
            chk($sformatf("hold_ready_%0d", i), {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("hold_release", {30'd0, in_ready, out_valid}, 32'd2);
        step();
        chk("hold_no_consume", {30'd0, in_ready, out_valid}, 32'd2);

        // Reset in the middle of RUN abandons the operation.
        in_valid = 1'b1;
        in_a     = 8'd100;
        in_b     = 8'd100;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("abort_running", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_product", {16'd0, product}, 32'd0);
        #2;
        rst_n = 1'b1;
        run_op("after_abort", 8'd7, 8'd9, 16'h003F);
        extra = 0;
        repeat (12) begin
            step();
            if (out_valid) extra++;
        end
        chk("abort_no_stale_out", extra, 0);

        // Back-to-back with in_valid held high.
        in_valid = 1'b1;
        in_a     = ba[0];
        in_b     = bb[0];
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!in_ready && n < 30) begin
                step();
                n++;
            end
            chk($sformatf("b2b%0d_ready", k), {31'd0, in_ready}, 32'd1);
            step();
            if (k < 2) begin
                in_a = ba[k+1];
                in_b = bb[k+1];
            end else begin
                in_valid = 1'b0;
            end
            wait_out(n);
            chk($sformatf("b2b%0d_latency", k), n, 8);
            chk($sformatf("b2b%0d_product", k), {16'd0, product}, {16'd0, bp[k]});
            step();
        end
        extra = 0;
        repeat (12) begin
            step();
            if (out_valid) extra++;
        end
        chk("b2b_no_duplicate", extra, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
